control_sequencer: RTL and testbench

- Moore-style control unit for the G2 CPU. It sits directly upstream of the Datapath and generates every control strobe the datapath consumes.
- It fetches and executes one instruction per pass through steps T0–T5, then repeats.
- Covers fetch plus register-format ALU instructions, unary ALU instructions, nop and halt.
- Register selection uses the Gra/Grb/Grc + Rin/Rout select-and-encode scheme; there are no per-register strobes.

---
 rtl/cpu_pkg.sv | 77 +++++++
 rtl/opcode_classifier.sv | 28 ++
 rtl/control_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the G2 control path: opcodes, sequencer state
// encoding, opcode classes and the packed control-strobe bundle.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 5;

  // Supported opcodes (ir[31:27])
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  // Step states use their step number as encoding so tstep falls out directly
  typedef enum logic [2:0] {
    T0      = 3'd0,
    T1      = 3'd1,
    T2      = 3'd2,
    T3      = 3'd3,
    T4      = 3'd4,
    T5      = 3'd5,
    HALT    = 3'd6,
    RESET_S = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_BIN     = 2'd0,
    CLS_UNARY   = 2'd1,
    CLS_NOP     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_t;

  // One bit per datapath strobe, plus ALU-op enable
  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic run;
    logic illegal;
    logic alu_en;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Debug step index: 0-5 for execution steps, 7 for reset/halt
  function automatic logic [2:0] step_index(input state_t s);
    logic [2:0] idx;
    if (s == HALT || s == RESET_S) begin
      idx = 3'd7;
    end else begin
      idx = s;
    end
    return idx;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode: maps an opcode to its execution class and
// flags the halt opcode.
module opcode_classifier
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class,
  output logic                is_halt
);

  // Class lookup; unsupported opcodes fall to CLS_ILLEGAL
  always_comb begin
    op_class = CLS_ILLEGAL;
    is_halt  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: op_class = CLS_BIN;
      OP_NEG, OP_NOT:                  op_class = CLS_UNARY;
      OP_NOP:                          op_class = CLS_NOP;
      OP_HALT: begin
        op_class = CLS_NOP;
        is_halt  = 1'b1;
      end
      default:                         op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit for the G2 CPU: steps T0-T5 per instruction, strobes
// decoded purely from the state, class and opcode registers.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [IRW-1:0] ir,
  input  logic           stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           Run,
  output logic           illegal,
  output logic [2:0]     tstep
);

  state_t    state;
  state_t    state_nxt;
  state_t    boundary_nxt;
  op_class_t cls_q;
  op_class_t dec_class;
  logic      dec_halt;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] opcode;
  ctrl_t     ctrl;
  logic      unused_ir_fields;

  assign opcode           = ir[IRW-1 -: OPW];
  assign unused_ir_fields = ^ir[IRW-OPW-1:0];

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (dec_class),
    .is_halt  (dec_halt)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_S;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture class and opcode as IR is loaded so later ir changes are ignored
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cls_q <= CLS_NOP;
      op_q  <= '0;
    end else if (state == T2) begin
      cls_q <= dec_class;
      op_q  <= opcode;
    end
  end

  // Next-state logic; stop is only honoured on the last step of an instruction
  always_comb begin
    boundary_nxt = stop ? HALT : T0;
    state_nxt    = state;
    case (state)
      RESET_S: state_nxt = T0;
      T0:      state_nxt = T1;
      T1:      state_nxt = T2;
      T2:      state_nxt = dec_halt ? HALT : T3;
      T3: begin
        if (cls_q == CLS_BIN || cls_q == CLS_UNARY) begin
          state_nxt = T4;
        end else begin
          state_nxt = boundary_nxt;
        end
      end
      T4:      state_nxt = (cls_q == CLS_BIN) ? T5 : boundary_nxt;
      T5:      state_nxt = boundary_nxt;
      HALT:    state_nxt = HALT;
      default: state_nxt = RESET_S;
    endcase
  end

  // Strobe decode from registered state/class only (Moore outputs)
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      T0: begin
        ctrl.run    = 1'b1;
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      T1: begin
        ctrl.run      = 1'b1;
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      T2: begin
        ctrl.run     = 1'b1;
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      T3: begin
        ctrl.run = 1'b1;
        case (cls_q)
          CLS_BIN: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          CLS_UNARY: begin
            ctrl.grb    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.z_in   = 1'b1;
            ctrl.alu_en = 1'b1;
          end
          CLS_ILLEGAL: ctrl.illegal = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        ctrl.run = 1'b1;
        if (cls_q == CLS_BIN) begin
          ctrl.grc    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_en = 1'b1;
        end else begin
          ctrl.zlow_out = 1'b1;
          ctrl.gra      = 1'b1;
          ctrl.r_in     = 1'b1;
        end
      end
      T5: begin
        ctrl.run      = 1'b1;
        ctrl.zlow_out = 1'b1;
        ctrl.gra      = 1'b1;
        ctrl.r_in     = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

  assign PCout   = ctrl.pc_out;
  assign Zlowout = ctrl.zlow_out;
  assign MDRout  = ctrl.mdr_out;
  assign MARin   = ctrl.mar_in;
  assign Zin     = ctrl.z_in;
  assign PCin    = ctrl.pc_in;
  assign MDRin   = ctrl.mdr_in;
  assign IRin    = ctrl.ir_in;
  assign Yin     = ctrl.y_in;
  assign IncPC   = ctrl.inc_pc;
  assign Read    = ctrl.read;
  assign Gra     = ctrl.gra;
  assign Grb     = ctrl.grb;
  assign Grc     = ctrl.grc;
  assign Rin     = ctrl.r_in;
  assign Rout    = ctrl.r_out;
  assign Run     = ctrl.run;
  assign illegal = ctrl.illegal;
  assign alu_op  = ctrl.alu_en ? op_q : '0;
  assign tstep   = step_index(state);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks and/neg/nop/halt/illegal
// instructions, stop at boundary and async reset, with a per-cycle legality monitor.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic        stop;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, illegal;
  logic [4:0]  alu_op;
  logic [2:0]  tstep;
  logic [17:0] strobes;
  logic        mon_en = 1'b0;

  int tests  = 0;
  int failed = 0;

  localparam logic [17:0] B_PCOUT   = 18'd1 << 17;
  localparam logic [17:0] B_ZLOWOUT = 18'd1 << 16;
  localparam logic [17:0] B_MDROUT  = 18'd1 << 15;
  localparam logic [17:0] B_MARIN   = 18'd1 << 14;
  localparam logic [17:0] B_ZIN     = 18'd1 << 13;
  localparam logic [17:0] B_PCIN    = 18'd1 << 12;
  localparam logic [17:0] B_MDRIN   = 18'd1 << 11;
  localparam logic [17:0] B_IRIN    = 18'd1 << 10;
  localparam logic [17:0] B_YIN     = 18'd1 << 9;
  localparam logic [17:0] B_INCPC   = 18'd1 << 8;
  localparam logic [17:0] B_READ    = 18'd1 << 7;
  localparam logic [17:0] B_GRA     = 18'd1 << 6;
  localparam logic [17:0] B_GRB     = 18'd1 << 5;
  localparam logic [17:0] B_GRC     = 18'd1 << 4;
  localparam logic [17:0] B_RIN     = 18'd1 << 3;
  localparam logic [17:0] B_ROUT    = 18'd1 << 2;
  localparam logic [17:0] B_RUN     = 18'd1 << 1;
  localparam logic [17:0] B_ILLEGAL = 18'd1 << 0;

  localparam logic [17:0] E_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [17:0] E_T1  = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [17:0] E_T2  = B_MDROUT | B_IRIN | B_RUN;
  localparam logic [17:0] E_B3  = B_GRB | B_ROUT | B_YIN | B_RUN;
  localparam logic [17:0] E_B4  = B_GRC | B_ROUT | B_ZIN | B_RUN;
  localparam logic [17:0] E_B5  = B_ZLOWOUT | B_GRA | B_RIN | B_RUN;
  localparam logic [17:0] E_U3  = B_GRB | B_ROUT | B_ZIN | B_RUN;
  localparam logic [17:0] E_U4  = B_ZLOWOUT | B_GRA | B_RIN | B_RUN;
  localparam logic [17:0] E_N3  = B_RUN;
  localparam logic [17:0] E_I3  = B_RUN | B_ILLEGAL;
  localparam logic [17:0] E_OFF = 18'd0;

  localparam logic [31:0] IR_AND  = 32'h2891_8000;
  localparam logic [31:0] IR_NEG  = 32'h8890_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;

  assign strobes = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
                    IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, illegal};

  control_sequencer #(.OPW(5), .IRW(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ir      (ir),
    .stop    (stop),
    .PCout   (PCout),
    .Zlowout (Zlowout),
    .MDRout  (MDRout),
    .MARin   (MARin),
    .Zin     (Zin),
    .PCin    (PCin),
    .MDRin   (MDRin),
    .IRin    (IRin),
    .Yin     (Yin),
    .IncPC   (IncPC),
    .Read    (Read),
    .Gra     (Gra),
    .Grb     (Grb),
    .Grc     (Grc),
    .Rin     (Rin),
    .Rout    (Rout),
    .alu_op  (alu_op),
    .Run     (Run),
    .illegal (illegal),
    .tstep   (tstep)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_step(input string tag, input logic [2:0] ts,
                             input logic [17:0] sv, input logic [4:0] alu);
    check({tag, "_tstep"}, 32'(tstep), 32'(ts));
    check({tag, "_strobes"}, 32'(strobes), 32'(sv));
    check({tag, "_alu"}, 32'(alu_op), 32'(alu));
  endtask

  // Per-cycle legality: single bus driver, register select one-hot, no X
  always @(negedge clock) begin
    if (mon_en) begin
      check("one_bus_driver", 32'($countones({PCout, Zlowout, MDRout, Rout}) <= 1), 32'd1);
      check("gr_select", 32'(!(Rin || Rout) || ($countones({Gra, Grb, Grc}) == 1)), 32'd1);
      check("no_x", 32'($isunknown({strobes, alu_op, tstep})), 32'd0);
    end
  end

  initial begin
    reset_n = 1'b0;
    stop    = 1'b0;
    ir      = '0;

    repeat (3) tick();
    mon_en = 1'b1;
    expect_step("reset", 3'd7, E_OFF, 5'd0);

    // and R1,R2,R3: full binary sequence
    ir      = IR_AND;
    reset_n = 1'b1;
    tick(); expect_step("and_t0", 3'd0, E_T0, 5'd0);
    tick(); expect_step("and_t1", 3'd1, E_T1, 5'd0);
    tick(); expect_step("and_t2", 3'd2, E_T2, 5'd0);
    tick(); expect_step("and_t3", 3'd3, E_B3, 5'd0);
    tick(); expect_step("and_t4", 3'd4, E_B4, 5'b00101);
    tick(); expect_step("and_t5", 3'd5, E_B5, 5'd0);
    tick(); expect_step("and_next_t0", 3'd0, E_T0, 5'd0);

    // neg: unary sequence
    ir = IR_NEG;
    tick(); expect_step("neg_t1", 3'd1, E_T1, 5'd0);
    tick(); expect_step("neg_t2", 3'd2, E_T2, 5'd0);
    tick(); expect_step("neg_t3", 3'd3, E_U3, 5'b10001);
    tick(); expect_step("neg_t4", 3'd4, E_U4, 5'd0);
    tick(); expect_step("neg_next_t0", 3'd0, E_T0, 5'd0);

    // nop, then ir changes to halt after class is latched
    ir = IR_NOP;
    tick(); expect_step("nop_t1", 3'd1, E_T1, 5'd0);
    tick(); expect_step("nop_t2", 3'd2, E_T2, 5'd0);
    tick(); expect_step("nop_t3", 3'd3, E_N3, 5'd0);
    ir = IR_HALT;
    tick(); expect_step("nop_next_t0", 3'd0, E_T0, 5'd0);
    tick(); expect_step("halt_t1", 3'd1, E_T1, 5'd0);
    tick(); expect_step("halt_t2", 3'd2, E_T2, 5'd0);
    for (int i = 0; i < 20; i++) begin
      tick(); expect_step("halted", 3'd7, E_OFF, 5'd0);
    end

    // illegal opcode after reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ir      = IR_ILL;
    tick(); expect_step("ill_t0", 3'd0, E_T0, 5'd0);
    tick(); expect_step("ill_t1", 3'd1, E_T1, 5'd0);
    tick(); expect_step("ill_t2", 3'd2, E_T2, 5'd0);
    tick(); expect_step("ill_t3", 3'd3, E_I3, 5'd0);
    tick(); expect_step("ill_next_t0", 3'd0, E_T0, 5'd0);

    // stop raised in T4: instruction completes, then HALT
    ir = IR_AND;
    tick(); expect_step("stop_t1", 3'd1, E_T1, 5'd0);
    tick(); expect_step("stop_t2", 3'd2, E_T2, 5'd0);
    tick(); expect_step("stop_t3", 3'd3, E_B3, 5'd0);
    tick(); expect_step("stop_t4", 3'd4, E_B4, 5'b00101);
    stop = 1'b1;
    tick(); expect_step("stop_t5", 3'd5, E_B5, 5'd0);
    tick(); expect_step("stop_halt", 3'd7, E_OFF, 5'd0);
    stop = 1'b0;

    // async reset in the middle of T4
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); expect_step("ar_t0", 3'd0, E_T0, 5'd0);
    tick(); expect_step("ar_t1", 3'd1, E_T1, 5'd0);
    tick(); expect_step("ar_t2", 3'd2, E_T2, 5'd0);
    tick(); expect_step("ar_t3", 3'd3, E_B3, 5'd0);
    tick(); expect_step("ar_t4", 3'd4, E_B4, 5'b00101);
    #1 reset_n = 1'b0;
    #1 expect_step("ar_async", 3'd7, E_OFF, 5'd0);
    tick();
    reset_n = 1'b1;
    tick(); expect_step("ar_restart_t0", 3'd0, E_T0, 5'd0);
    tick(); expect_step("ar_restart_t1", 3'd1, E_T1, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
